// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types for the data-memory arbiter.
//   arb_state_e : last-owner record kept by the arbiter FSM
//   arb_owner_e : combinational winner of the current cycle
//   burst_cnt_width() : width of the host burst counter for a given MAX_BURST
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        CORE_LAST   = 2'd1,
        HOST_LAST   = 2'd2,
        HOST_LOCKED = 2'd3
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } arb_owner_e;

    // The counter must be able to hold the value MAX_BURST itself.
    function automatic int unsigned burst_cnt_width(input int unsigned max_burst);
        return $clog2(max_burst + 32'd1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_if
// Bundles both requester ports (core, host) and the data_mem side of the
// arbiter.
//   slave  : arbiter view (requests and mem_rdata in; grants, read data and
//            memory controls out)
//   master : environment view (core, host and data_mem together)
// -----------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int unsigned AW = 8,
    parameter int unsigned DW = 8
);
    // core requester
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_stall;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;
    // host requester
    logic          host_req;
    logic          host_we;
    logic          host_lock;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [DW-1:0] host_rdata;
    // data_mem side
    logic [AW-1:0] mem_addr;
    logic          mem_read;
    logic          mem_write;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  host_req, host_we, host_lock, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_addr, mem_read, mem_write, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output host_req, host_we, host_lock, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_burst_ctr.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_burst_ctr
// Saturating counter of consecutive locked host grants taken while the core
// is waiting.
//   clk, start_n : clock, async active-low reset
//   inc          : count one more locked host grant (stops at limit)
//   clr          : clear to zero (wins over inc)
//   limit        : saturation value
//   cnt          : current count
//   at_limit     : cnt == limit
// -----------------------------------------------------------------------------
module dmem_arbiter_burst_ctr #(
    parameter int unsigned CW = 3
) (
    input  logic          clk,
    input  logic          start_n,
    input  logic          inc,
    input  logic          clr,
    input  logic [CW-1:0] limit,
    output logic [CW-1:0] cnt,
    output logic          at_limit
);

    logic [CW-1:0] cnt_r;

    // Count register: clear has priority, increment saturates at limit
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (inc && (cnt_r != limit)) begin
            cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt      = cnt_r;
    assign at_limit = (cnt_r == limit);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one data_mem between the core load/store path and a host port.
// Round-robin on contention, with a host lock that is bounded so the core
// waits at most MAX_BURST+1 cycles.
//   clk      : system clock
//   start_n  : asynchronous active-low reset
//   bus      : dmem_arbiter_if.slave
//              core_* : core request / grant / stall / read return
//              host_* : host request (with lock) / grant / read return
//              mem_*  : data_mem addr, read/write strobes, write/read data
// Grants and memory controls are combinational from the current requests and
// the registered last-owner state; read data returns one cycle after grant.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 8,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           start_n,
    dmem_arbiter_if.slave  bus
);

    localparam int unsigned CW = burst_cnt_width(MAX_BURST);

    arb_state_e    state_r;
    arb_state_e    state_nxt_s;
    arb_owner_e    winner_s;
    logic          lock_hold_s;
    logic          core_gnt_s;
    logic          host_gnt_s;
    logic          cnt_inc_s;
    logic          cnt_clr_s;
    logic          at_limit_s;
    logic [CW-1:0] burst_cnt_s;
    logic          core_rvalid_r;
    logic [DW-1:0] core_rdata_r;
    logic          host_rvalid_r;
    logic [DW-1:0] host_rdata_r;

    // The host keeps a lock only while the core has not yet waited the full burst.
    assign lock_hold_s = (state_r == HOST_LOCKED) && bus.host_req && bus.host_lock &&
                         (!at_limit_s || !bus.core_req);

    // Winner selection: held lock first, then alternate owners on contention
    always_comb begin
        winner_s = OWN_NONE;
        if (!start_n) begin
            winner_s = OWN_NONE;
        end else if (lock_hold_s) begin
            winner_s = OWN_HOST;
        end else if (bus.core_req && bus.host_req) begin
            case (state_r)
                CORE_LAST:   winner_s = OWN_HOST;
                HOST_LAST:   winner_s = OWN_CORE;
                HOST_LOCKED: winner_s = OWN_CORE;
                IDLE:        winner_s = OWN_CORE;
                default:     winner_s = OWN_CORE;
            endcase
        end else if (bus.core_req) begin
            winner_s = OWN_CORE;
        end else if (bus.host_req) begin
            winner_s = OWN_HOST;
        end else begin
            winner_s = OWN_NONE;
        end
    end

    assign core_gnt_s = (winner_s == OWN_CORE);
    assign host_gnt_s = (winner_s == OWN_HOST);

    // Memory-side mux: winner drives addr/data/strobes, all zero when idle
    always_comb begin
        bus.mem_addr  = {AW{1'b0}};
        bus.mem_wdata = {DW{1'b0}};
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        case (winner_s)
            OWN_CORE: begin
                bus.mem_addr  = bus.core_addr;
                bus.mem_wdata = bus.core_wdata;
                bus.mem_read  = !bus.core_we;
                bus.mem_write = bus.core_we;
            end
            OWN_HOST: begin
                bus.mem_addr  = bus.host_addr;
                bus.mem_wdata = bus.host_wdata;
                bus.mem_read  = !bus.host_we;
                bus.mem_write = bus.host_we;
            end
            default: begin
                bus.mem_addr  = {AW{1'b0}};
                bus.mem_wdata = {DW{1'b0}};
                bus.mem_read  = 1'b0;
                bus.mem_write = 1'b0;
            end
        endcase
    end

    assign bus.core_gnt   = core_gnt_s;
    assign bus.host_gnt   = host_gnt_s;
    // Stall is suppressed in reset so every output is quiet while start_n is low.
    assign bus.core_stall = start_n && bus.core_req && !core_gnt_s;

    // Next-state: remember who owned the memory last; hold when nobody did
    always_comb begin
        state_nxt_s = state_r;
        case (winner_s)
            OWN_CORE: state_nxt_s = CORE_LAST;
            OWN_HOST: begin
                if (bus.host_lock) begin
                    state_nxt_s = HOST_LOCKED;
                end else begin
                    state_nxt_s = HOST_LAST;
                end
            end
            default:  state_nxt_s = state_r;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Only locked grants taken while the core is waiting count toward the bound.
    assign cnt_inc_s = host_gnt_s && (state_r == HOST_LOCKED) && bus.core_req;
    assign cnt_clr_s = core_gnt_s || (host_gnt_s && !bus.host_lock);

    dmem_arbiter_burst_ctr #(
        .CW (CW)
    ) u_burst_ctr (
        .clk      (clk),
        .start_n  (start_n),
        .inc      (cnt_inc_s),
        .clr      (cnt_clr_s),
        .limit    (CW'(MAX_BURST)),
        .cnt      (burst_cnt_s),
        .at_limit (at_limit_s)
    );

    // Read return: capture data_mem output for the reader, one-cycle valid pulse
    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            core_rvalid_r <= 1'b0;
            core_rdata_r  <= {DW{1'b0}};
            host_rvalid_r <= 1'b0;
            host_rdata_r  <= {DW{1'b0}};
        end else begin
            core_rvalid_r <= core_gnt_s && !bus.core_we;
            host_rvalid_r <= host_gnt_s && !bus.host_we;
            if (core_gnt_s && !bus.core_we) begin
                core_rdata_r <= bus.mem_rdata;
            end else begin
                core_rdata_r <= core_rdata_r;
            end
            if (host_gnt_s && !bus.host_we) begin
                host_rdata_r <= bus.mem_rdata;
            end else begin
                host_rdata_r <= host_rdata_r;
            end
        end
    end

    assign bus.core_rvalid = core_rvalid_r;
    assign bus.core_rdata  = core_rdata_r;
    assign bus.host_rvalid = host_rvalid_r;
    assign bus.host_rdata  = host_rdata_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter (AW=8, DW=8, MAX_BURST=4) with a small
// behavioural data_mem (combinational read, write on the clock edge).
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic start_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    // Clock generator
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(8), .DW(8)) bus ();

    dmem_arbiter #(
        .AW        (8),
        .DW        (8),
        .MAX_BURST (4)
    ) dut (
        .clk     (clk),
        .start_n (start_n),
        .bus     (bus.slave)
    );

    logic [7:0] mem_model [256];

    // data_mem stand-in: write on the clock edge
    always @(posedge clk) begin
        if (bus.mem_write) mem_model[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = mem_model[bus.mem_addr];

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_core(input logic req, input logic we, input logic [7:0] addr,
                            input logic [7:0] wdata);
        bus.core_req   = req;
        bus.core_we    = we;
        bus.core_addr  = addr;
        bus.core_wdata = wdata;
    endtask

    task automatic set_host(input logic req, input logic we, input logic lock,
                            input logic [7:0] addr, input logic [7:0] wdata);
        bus.host_req   = req;
        bus.host_we    = we;
        bus.host_lock  = lock;
        bus.host_addr  = addr;
        bus.host_wdata = wdata;
    endtask

    task automatic chk_quiet(input string pfx);
        chk({pfx, "_core_gnt"},    32'(bus.core_gnt),    0);
        chk({pfx, "_core_stall"},  32'(bus.core_stall),  0);
        chk({pfx, "_core_rvalid"}, 32'(bus.core_rvalid), 0);
        chk({pfx, "_core_rdata"},  32'(bus.core_rdata),  0);
        chk({pfx, "_host_gnt"},    32'(bus.host_gnt),    0);
        chk({pfx, "_host_rvalid"}, 32'(bus.host_rvalid), 0);
        chk({pfx, "_host_rdata"},  32'(bus.host_rdata),  0);
        chk({pfx, "_mem_read"},    32'(bus.mem_read),    0);
        chk({pfx, "_mem_write"},   32'(bus.mem_write),   0);
        chk({pfx, "_mem_addr"},    32'(bus.mem_addr),    0);
    endtask

    task automatic do_reset();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        start_n = 1'b0;
        tick();
        start_n = 1'b1;
    endtask

    // Watchdog
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        logic [3:0] alt_core;
        logic [5:0] lk_core;
        logic [5:0] lk_host;
        alt_core = 4'b0101;
        lk_core  = 6'b010000;
        lk_host  = 6'b101111;

        start_n = 1'b0;
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        mid();
        chk_quiet("rst");
        tick();
        start_n = 1'b1;

        // Reset arriving mid-read drops the pending rvalid
        set_core(1'b1, 1'b0, 8'h10, 8'h00);
        mid();
        chk("midrd_gnt", 32'(bus.core_gnt), 1);
        chk("midrd_mem_read", 32'(bus.mem_read), 1);
        #1 start_n = 1'b0;
        #1 chk_quiet("midrd_inrst");
        tick();
        chk_quiet("midrd_after");
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        start_n = 1'b1;

        // Core write then read of the same address
        tick();
        set_core(1'b1, 1'b1, 8'h10, 8'hA5);
        mid();
        chk("cw_gnt", 32'(bus.core_gnt), 1);
        chk("cw_stall", 32'(bus.core_stall), 0);
        chk("cw_mem_write", 32'(bus.mem_write), 1);
        chk("cw_mem_addr", 32'(bus.mem_addr), 32'h10);
        chk("cw_mem_wdata", 32'(bus.mem_wdata), 32'hA5);
        tick();
        set_core(1'b1, 1'b0, 8'h10, 8'h00);
        mid();
        chk("cr_gnt", 32'(bus.core_gnt), 1);
        chk("cr_stall", 32'(bus.core_stall), 0);
        chk("cr_mem_read", 32'(bus.mem_read), 1);
        chk("cr_rvalid_early", 32'(bus.core_rvalid), 0);
        tick();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        mid();
        chk("cr_rvalid", 32'(bus.core_rvalid), 1);
        chk("cr_rdata", 32'(bus.core_rdata), 32'hA5);
        chk("cr_idle_mem_read", 32'(bus.mem_read), 0);
        tick();
        mid();
        chk("cr_rvalid_pulse", 32'(bus.core_rvalid), 0);
        chk("cr_rdata_hold", 32'(bus.core_rdata), 32'hA5);

        // Contention from IDLE alternates core, host, core, host
        tick();
        do_reset();
        set_core(1'b1, 1'b0, 8'h20, 8'h00);
        set_host(1'b1, 1'b0, 1'b0, 8'h30, 8'h00);
        for (int i = 0; i < 4; i++) begin
            mid();
            chk($sformatf("alt_core_gnt%0d", i), 32'(bus.core_gnt), 32'(alt_core[i]));
            chk($sformatf("alt_host_gnt%0d", i), 32'(bus.host_gnt), 32'(!alt_core[i]));
            chk($sformatf("alt_stall%0d", i), 32'(bus.core_stall), 32'(!alt_core[i]));
            tick();
        end

        // Host lock with core waiting: bounded at MAX_BURST host grants
        do_reset();
        set_host(1'b1, 1'b0, 1'b1, 8'h40, 8'h00);
        for (int i = 0; i < 2; i++) begin
            mid();
            chk($sformatf("lk_pre_host%0d", i), 32'(bus.host_gnt), 1);
            tick();
        end
        set_core(1'b1, 1'b0, 8'h41, 8'h00);
        for (int c = 0; c < 6; c++) begin
            mid();
            chk($sformatf("lk_core_gnt%0d", c), 32'(bus.core_gnt), 32'(lk_core[c]));
            chk($sformatf("lk_host_gnt%0d", c), 32'(bus.host_gnt), 32'(lk_host[c]));
            chk($sformatf("lk_stall%0d", c), 32'(bus.core_stall), 32'(!lk_core[c]));
            tick();
        end

        // Host lock with the core idle never touches the burst counter
        do_reset();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        set_host(1'b1, 1'b0, 1'b1, 8'h50, 8'h00);
        for (int i = 0; i < 10; i++) begin
            mid();
            chk($sformatf("hl_host_gnt%0d", i), 32'(bus.host_gnt), 1);
            chk($sformatf("hl_core_gnt%0d", i), 32'(bus.core_gnt), 0);
            tick();
        end
        chk("hl_burst_cnt", 32'(dut.burst_cnt_s), 0);

        // Host write then core read of the same address on the next cycle
        set_host(1'b1, 1'b1, 1'b0, 8'hFF, 8'h3C);
        mid();
        chk("hw_gnt", 32'(bus.host_gnt), 1);
        chk("hw_mem_write", 32'(bus.mem_write), 1);
        chk("hw_mem_addr", 32'(bus.mem_addr), 32'hFF);
        tick();
        set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_core(1'b1, 1'b0, 8'hFF, 8'h00);
        mid();
        chk("hwcr_core_gnt", 32'(bus.core_gnt), 1);
        tick();
        set_core(1'b0, 1'b0, 8'h00, 8'h00);
        mid();
        chk("hwcr_rvalid", 32'(bus.core_rvalid), 1);
        chk("hwcr_rdata", 32'(bus.core_rdata), 32'h3C);
        chk("hwcr_host_rvalid", 32'(bus.host_rvalid), 0);

        // Host read returns on the host port only
        tick();
        set_host(1'b1, 1'b0, 1'b0, 8'h10, 8'h00);
        mid();
        chk("hr_gnt", 32'(bus.host_gnt), 1);
        tick();
        set_host(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        mid();
        chk("hr_rvalid", 32'(bus.host_rvalid), 1);
        chk("hr_rdata", 32'(bus.host_rdata), 32'hA5);
        chk("hr_core_rvalid", 32'(bus.core_rvalid), 0);
        chk("hr_core_rdata_hold", 32'(bus.core_rdata), 32'h3C);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data_mem instance between two requesters: the core (ControlUnit load/store path) and a host port (testbench loader / result dumper).
- Sits between the requesters and data_mem. Drives data_mem addr/ctrl_mem_read/ctrl_mem_write/data_in.
- Round-robin arbitration, plus a host burst lock whose length is bounded so the core cannot starve.
- Gives the core a stall signal so IF can freeze the PC while the core is waiting for memory.

Parameters:
- AW, 8, address width; matches data_mem.
- DW, 8, data width.
- MAX_BURST, 4, maximum consecutive locked host grants while the core is waiting; legal range 1..15.

Ports:
- clk  in  1  system clock
- start_n  in  1  asynchronous active-low reset
- core_req  in  1  core requests a memory access this cycle
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  core address
- core_wdata  in  DW  core write data
- core_gnt  out  1  core access performed this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  core read data valid (one cycle)
- core_rdata  out  DW  core read data
- host_req  in  1  host requests a memory access
- host_we  in  1  1 = write, 0 = read
- host_lock  in  1  host requests back-to-back ownership
- host_addr  in  AW  host address
- host_wdata  in  DW  host write data
- host_gnt  out  1  host access performed this cycle
- host_rvalid  out  1  host read data valid (one cycle)
- host_rdata  out  DW  host read data
- mem_addr  out  AW  to data_mem addr
- mem_read  out  1  to data_mem ctrl_mem_read
- mem_write  out  1  to data_mem ctrl_mem_write
- mem_wdata  out  DW  to data_mem data_in
- mem_rdata  in  DW  from data_mem data_out (combinational read)

Behaviour:
- Reset (async, start_n=0):
  - state=IDLE, burst_cnt=0.
  - All gnt, rvalid and rdata outputs are 0; mem_read and mem_write are 0.
  - An rvalid that was pending when reset asserted is dropped.
- State register is an enum {IDLE, CORE_LAST, HOST_LAST, HOST_LOCKED}. It records the last owner.
- Grant decision is combinational from the current req signals and the registered state. At most one gnt is high per cycle.
  - HOST_LOCKED & host_req & host_lock & (burst_cnt<MAX_BURST or ~core_req) -> host.
  - Otherwise, both requesting -> the requester that was not last owner. In IDLE, core wins.
  - Otherwise, the single requester wins. No request -> no grant.
- Memory side is combinational from the winner:
  - mem_addr and mem_wdata are muxed from the winner; both are 0 when idle.
  - mem_read = gnt & ~we; mem_write = gnt & we.
  - The write commits on the same clk edge, inside data_mem.
- Read return, at posedge after the grant cycle:
  - The winner's rdata is loaded from mem_rdata and its rvalid is 1 for exactly one cycle. Read latency is 1.
  - rdata holds its value until the next read by the same requester.
- Transitions, at posedge:
  - Core grant -> CORE_LAST.
  - Host grant with host_lock=1 -> HOST_LOCKED.
  - Host grant with host_lock=0 -> HOST_LAST.
  - No grant -> state held.
- burst_cnt:
  - +1 on each host grant while in HOST_LOCKED and core_req=1; saturates at MAX_BURST.
  - Cleared on any core grant, and on any host grant with host_lock=0.
- Starvation bound: a core request waits at most MAX_BURST+1 cycles. When burst_cnt==MAX_BURST and core_req=1, the core wins even if host_lock=1.
- Requester rule: req, we, addr and wdata are held stable until gnt. The arbiter does not latch requests.
- Same-address write and read in consecutive cycles: the read returns the new data, because data_mem writes on the edge.
- core_stall is purely combinational. IF uses it to hold the PC.

Decomposition:
- Package DMemArb_def:
  - typedef enum logic[1:0] ARB_STATE {IDLE, CORE_LAST, HOST_LAST, HOST_LOCKED}.
  - typedef enum logic[1:0] ARB_OWNER {OWN_NONE, OWN_CORE, OWN_HOST}.
- One sub-module: arb_burst_ctr, a saturating counter with inc, clr, limit and at_limit; width $clog2(MAX_BURST+1).
- Everything else stays in dmem_arbiter.

Test Plan:
- Reset mid-read: core read granted, start_n=0 before the next edge -> core_rvalid stays 0 and all outputs are 0.
- Core only, write addr 8'h10 data 8'hA5, then read 8'h10:
  - core_gnt=1 both cycles, core_stall=0.
  - core_rvalid=1 with rdata 8'hA5 one cycle after the read grant.
- Simultaneous requests from IDLE, both held for 4 cycles -> grants alternate core, host, core, host; core_stall=1 only on the host cycles.
- Host lock, MAX_BURST=4, host_req=host_lock=1 continuously, core_req rising on cycle 0 -> host granted cycles 0-3, core granted cycle 4, host again cycle 5.
- Host lock with core idle for 10 cycles -> host granted all 10 cycles, burst_cnt=0, core never granted.
- Host write 8'h3C to 8'hFF, then core read of 8'hFF on the next cycle -> core_rdata=8'h3C, host_rvalid stays 0.
